// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit multi-cycle CPU: opcodes, control FSM states, PC source codes.
package cpu_pkg;

  localparam logic [2:0] OP_RALU = 3'b000;
  localparam logic [2:0] OP_IALU = 3'b001;
  localparam logic [2:0] OP_LD   = 3'b010;
  localparam logic [2:0] OP_ST   = 3'b011;
  localparam logic [2:0] OP_BEQ  = 3'b100;
  localparam logic [2:0] OP_JMP  = 3'b101;
  localparam logic [2:0] OP_RSVD = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC   = 4'd3,
    ST_MEM    = 4'd4,
    ST_WB     = 4'd5,
    ST_BRANCH = 4'd6,
    ST_JUMP   = 4'd7,
    ST_HALT   = 4'd8,
    ST_FAULT  = 4'd9
  } state_t;

  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
// Memory wait counter with timeout compare; reusable by any req/ready memory master.
module mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_active,
  input  logic i_ready,
  output logic o_timeout
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_cnt <= '0;
    else if (i_start)
      r_cnt <= '0;
    else if (i_active && !i_ready)
      r_cnt <= r_cnt + CW'(1);
  end

  // Fires in the last permitted wait cycle, so a ready arriving in that same cycle still wins.
  assign o_timeout = (TIMEOUT > 0) && i_active && !i_ready && (r_cnt == LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the 16-bit CPU datapath.
// Optional retired-instruction counter enabled with `define CTRL_RETIRE_CNT_EN.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [2:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        iord,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  pc_src,
  output logic        regwrite,
  output logic        reg_dest,
  output logic        memtoreg,
  output logic        aluop,
  output logic        branch,
  output logic        jump,
  output logic        halted,
`ifdef CTRL_RETIRE_CNT_EN
  output logic        fault,
  output logic [15:0] retire_cnt
`else
  output logic        fault
`endif
);

  state_t     r_state;
  state_t     w_next;
  logic [2:0] r_op_q;
  logic       w_retire;
  logic       w_timer_start;
  logic       w_timer_active;
  logic       w_timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_op_q  <= OP_RALU;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE)
        r_op_q <= opcode;
    end
  end

  assign w_timer_active = (r_state == ST_FETCH) || (r_state == ST_MEM);
  assign w_timer_start  = ((w_next == ST_FETCH) || (w_next == ST_MEM)) && (w_next != r_state);

  mem_wait_timer #(
    .TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_start   (w_timer_start),
    .i_active  (w_timer_active),
    .i_ready   (mem_ready),
    .o_timeout (w_timeout)
  );

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    iord     = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    pc_src   = PC_SRC_INC;
    regwrite = 1'b0;
    reg_dest = 1'b0;
    memtoreg = 1'b0;
    aluop    = 1'b0;
    branch   = 1'b0;
    jump     = 1'b0;
    halted   = 1'b0;
    fault    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (run)
          w_next = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = ST_DECODE;
        end else if (w_timeout) begin
          w_next = ST_FAULT;
        end
      end
      ST_DECODE: begin
        // op_q is not loaded yet, so dispatch on the live IR field.
        case (opcode)
          OP_RALU, OP_IALU, OP_LD, OP_ST: w_next = ST_EXEC;
          OP_BEQ:                         w_next = ST_BRANCH;
          OP_JMP:                         w_next = ST_JUMP;
          OP_HALT:                        w_next = ST_HALT;
          default:                        w_next = ST_FAULT;
        endcase
      end
      ST_EXEC: begin
        aluop  = (r_op_q != OP_RALU);
        w_next = ((r_op_q == OP_RALU) || (r_op_q == OP_IALU)) ? ST_WB : ST_MEM;
      end
      ST_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (r_op_q == OP_ST);
        aluop   = 1'b1;
        if (mem_ready) begin
          if (r_op_q == OP_LD) begin
            w_next = ST_WB;
          end else begin
            w_retire = 1'b1;
            w_next   = run ? ST_FETCH : ST_IDLE;
          end
        end else if (w_timeout) begin
          w_next = ST_FAULT;
        end
      end
      ST_WB: begin
        regwrite = 1'b1;
        reg_dest = (r_op_q != OP_RALU);
        memtoreg = (r_op_q == OP_LD);
        w_retire = 1'b1;
        w_next   = run ? ST_FETCH : ST_IDLE;
      end
      ST_BRANCH: begin
        branch   = 1'b1;
        pc_src   = PC_SRC_BRANCH;
        pc_write = zero;
        w_retire = 1'b1;
        w_next   = run ? ST_FETCH : ST_IDLE;
      end
      ST_JUMP: begin
        jump     = 1'b1;
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
        w_retire = 1'b1;
        w_next   = run ? ST_FETCH : ST_IDLE;
      end
      ST_HALT:  halted = 1'b1;
      ST_FAULT: fault  = 1'b1;
      default:  w_next = ST_FAULT;
    endcase
  end

`ifdef CTRL_RETIRE_CNT_EN
  logic [15:0] r_retire_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_retire_cnt <= 16'h0000;
    else if (w_retire)
      r_retire_cnt <= r_retire_cnt + 16'h0001;
  end

  assign retire_cnt = r_retire_cnt;
`else
  logic w_retire_unused;
  assign w_retire_unused = w_retire;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl (MEM_TIMEOUT = 15).
module tb_multicycle_ctrl;

  localparam int TO = 15;

  // Expected output words: {mem_req, mem_we, iord, ir_write, pc_write, pc_src[1:0],
  //                         regwrite, reg_dest, memtoreg, aluop, branch, jump, halted, fault}
  localparam logic [14:0] E_ZERO   = 15'h0000;
  localparam logic [14:0] E_FWAIT  = 15'h4000;
  localparam logic [14:0] E_FOK    = 15'h4C00;
  localparam logic [14:0] E_ALUADD = 15'h0010;
  localparam logic [14:0] E_MEMLD  = 15'h5010;
  localparam logic [14:0] E_MEMST  = 15'h7010;
  localparam logic [14:0] E_WBR    = 15'h0080;
  localparam logic [14:0] E_WBI    = 15'h00C0;
  localparam logic [14:0] E_WBLD   = 15'h00E0;
  localparam logic [14:0] E_BR0    = 15'h0108;
  localparam logic [14:0] E_BR1    = 15'h0508;
  localparam logic [14:0] E_JMP    = 15'h0604;
  localparam logic [14:0] E_HALT   = 15'h0002;
  localparam logic [14:0] E_FAULT  = 15'h0001;

  typedef struct {
    string       name;
    logic        run;
    logic [2:0]  opcode;
    logic        zero;
    logic        mem_ready;
    logic [14:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [2:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_we, iord, ir_write, pc_write;
  logic [1:0]  pc_src;
  logic        regwrite, reg_dest, memtoreg, aluop, branch, jump, halted, fault;
  logic [14:0] w_out;
`ifdef CTRL_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  multicycle_ctrl #(
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .iord       (iord),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .regwrite   (regwrite),
    .reg_dest   (reg_dest),
    .memtoreg   (memtoreg),
    .aluop      (aluop),
    .branch     (branch),
    .jump       (jump),
    .halted     (halted),
`ifdef CTRL_RETIRE_CNT_EN
    .fault      (fault),
    .retire_cnt (retire_cnt)
`else
    .fault      (fault)
`endif
  );

  assign w_out = {mem_req, mem_we, iord, ir_write, pc_write, pc_src,
                  regwrite, reg_dest, memtoreg, aluop, branch, jump, halted, fault};

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [2:0] op, input logic z, input logic rdy);
    run       = r;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input string n, input logic r, input logic [2:0] op,
                     input logic z, input logic rdy, input logic [14:0] e);
    vec_t v;
    v.name = n; v.run = r; v.opcode = op; v.zero = z; v.mem_ready = rdy; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 3'b000, 1'b0, 1'b0);
    #2;
    check("reset_outputs", {1'b0, w_out}, {1'b0, E_ZERO});
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    do_reset();

    // Each row is one clock cycle starting from IDLE.
    add("idle_hold",      0, 3'b000, 0, 0, E_ZERO);
    add("idle_start",     1, 3'b000, 0, 1, E_ZERO);
    add("r_fetch",        1, 3'b000, 0, 1, E_FOK);
    add("r_decode",       1, 3'b000, 0, 1, E_ZERO);
    add("r_exec",         1, 3'b000, 0, 1, E_ZERO);
    add("r_wb",           1, 3'b000, 0, 1, E_WBR);
    add("i_fetch",        1, 3'b001, 0, 1, E_FOK);
    add("i_decode",       1, 3'b001, 0, 1, E_ZERO);
    add("i_exec",         1, 3'b001, 0, 1, E_ALUADD);
    add("i_wb",           1, 3'b001, 0, 1, E_WBI);
    add("ld_fetch",       1, 3'b010, 0, 1, E_FOK);
    add("ld_decode",      1, 3'b010, 0, 1, E_ZERO);
    add("ld_exec_opq",    1, 3'b000, 0, 1, E_ALUADD);
    add("ld_mem_wait1",   1, 3'b000, 0, 0, E_MEMLD);
    add("ld_mem_wait2",   1, 3'b000, 0, 0, E_MEMLD);
    add("ld_mem_wait3",   1, 3'b000, 0, 0, E_MEMLD);
    add("ld_mem_ready",   1, 3'b000, 0, 1, E_MEMLD);
    add("ld_wb",          1, 3'b000, 0, 1, E_WBLD);
    add("st_fetch",       1, 3'b011, 0, 1, E_FOK);
    add("st_decode",      1, 3'b011, 0, 1, E_ZERO);
    add("st_exec_opq",    1, 3'b101, 0, 1, E_ALUADD);
    add("st_mem",         1, 3'b101, 0, 1, E_MEMST);
    add("beq0_fetch",     1, 3'b100, 0, 1, E_FOK);
    add("beq0_decode",    1, 3'b100, 0, 1, E_ZERO);
    add("beq_zero0",      1, 3'b100, 0, 1, E_BR0);
    add("beq1_fetch",     1, 3'b100, 1, 1, E_FOK);
    add("beq1_decode",    1, 3'b100, 1, 1, E_ZERO);
    add("beq_zero1",      1, 3'b100, 1, 1, E_BR1);
    add("jmp_fetch",      1, 3'b101, 0, 1, E_FOK);
    add("jmp_decode",     1, 3'b101, 0, 1, E_ZERO);
    add("jmp_stop",       0, 3'b101, 0, 1, E_JMP);
    add("idle_after_jmp", 0, 3'b101, 0, 1, E_ZERO);
    add("restart",        1, 3'b000, 0, 1, E_ZERO);
    add("norun_fetch",    0, 3'b000, 0, 1, E_FOK);
    add("norun_decode",   0, 3'b000, 0, 1, E_ZERO);
    add("norun_exec",     0, 3'b000, 0, 1, E_ZERO);
    add("norun_wb",       0, 3'b000, 0, 1, E_WBR);
    add("norun_idle",     0, 3'b000, 0, 1, E_ZERO);
    add("halt_start",     1, 3'b111, 0, 1, E_ZERO);
    add("halt_fetch",     1, 3'b111, 0, 1, E_FOK);
    add("halt_decode",    1, 3'b111, 0, 1, E_ZERO);
    add("halted",         1, 3'b111, 0, 1, E_HALT);
    add("halted_sticky",  1, 3'b000, 1, 1, E_HALT);

    foreach (vecs[i]) begin
      drive(vecs[i].run, vecs[i].opcode, vecs[i].zero, vecs[i].mem_ready);
      #2;
      check(vecs[i].name, {1'b0, w_out}, {1'b0, vecs[i].exp});
      tick();
    end

    // FETCH timeout: fault after exactly TO waiting cycles, then sticky.
    do_reset();
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < TO; i++) begin
      #2;
      check($sformatf("fetch_wait_%0d", i + 1), {1'b0, w_out}, {1'b0, E_FWAIT});
      tick();
    end
    #2;
    check("fetch_timeout", {1'b0, w_out}, {1'b0, E_FAULT});
    drive(1'b1, 3'b000, 1'b0, 1'b1);
    repeat (3) tick();
    #2;
    check("fault_sticky", {1'b0, w_out}, {1'b0, E_FAULT});

    // Ready in the last permitted cycle is accepted.
    do_reset();
    drive(1'b1, 3'b000, 1'b0, 1'b0);
    repeat (TO) tick();
    drive(1'b1, 3'b000, 1'b0, 1'b1);
    #2;
    check("fetch_last_ready", {1'b0, w_out}, {1'b0, E_FOK});
    tick();
    #2;
    check("late_decode", {1'b0, w_out}, {1'b0, E_ZERO});
    tick();
    #2;
    check("late_exec_nofault", {1'b0, w_out}, {1'b0, E_ZERO});

    // MEM timeout on a load that never completes; counter restarted on MEM entry.
    do_reset();
    drive(1'b1, 3'b010, 1'b0, 1'b0);
    repeat (3) tick();
    drive(1'b1, 3'b010, 1'b0, 1'b1);
    repeat (3) tick();
    drive(1'b1, 3'b010, 1'b0, 1'b0);
    repeat (TO - 1) tick();
    #2;
    check("mem_wait_last", {1'b0, w_out}, {1'b0, E_MEMLD});
    tick();
    #2;
    check("mem_timeout", {1'b0, w_out}, {1'b0, E_FAULT});

    // Illegal opcode.
    do_reset();
    drive(1'b1, 3'b110, 1'b0, 1'b1);
    repeat (2) tick();
    #2;
    check("illegal_decode", {1'b0, w_out}, {1'b0, E_ZERO});
    tick();
    #2;
    check("illegal_fault", {1'b0, w_out}, {1'b0, E_FAULT});

    // Reset asserted in the middle of a store's MEM cycle.
    do_reset();
    drive(1'b1, 3'b011, 1'b0, 1'b1);
    repeat (4) tick();
    drive(1'b1, 3'b011, 1'b0, 1'b0);
    #2;
    check("st_mem_before_reset", {1'b0, w_out}, {1'b0, E_MEMST});
    reset = 1'b1;
    #1;
    check("reset_mid_mem", {1'b0, w_out}, {1'b0, E_ZERO});
    tick();
    reset = 1'b0;
    drive(1'b0, 3'b011, 1'b0, 1'b1);
    #2;
    check("idle_after_reset", {1'b0, w_out}, {1'b0, E_ZERO});

`ifdef CTRL_RETIRE_CNT_EN
    // Five back-to-back stores then HALT.
    do_reset();
    drive(1'b1, 3'b011, 1'b0, 1'b1);
    repeat (21) tick();
    #2;
    check("retire_5_st", retire_cnt, 16'd5);
    drive(1'b1, 3'b111, 1'b0, 1'b1);
    repeat (3) tick();
    #2;
    check("retire_halt_nocount", retire_cnt, 16'd5);
    check("retire_halted", {1'b0, w_out}, {1'b0, E_HALT});

    // Wrap from FFFF to 0 on one retired jump.
    do_reset();
    dut.r_retire_cnt = 16'hFFFF;
    drive(1'b1, 3'b101, 1'b0, 1'b1);
    repeat (4) tick();
    #2;
    check("retire_wrap", retire_cnt, 16'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
